rgb_gray_converter: RTL and testbench

RGB_GRAY_CONVERTER -- requirements
Module: rgb_gray_converter

---
 rtl/rgb_gray_pkg.sv | 15 +
 rtl/rgb_gray_pixel_mac.sv | 48 ++++
 rtl/rgb_gray_converter.sv | 50 +++++
 tb/tb_rgb_gray_converter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_gray_pkg.sv
// Shared constants for the RGB-to-grayscale converter: sample/index widths and the
// fixed-point luma weights (sum to 256, so the rounded result always fits in 8 bits).
package rgb_gray_pkg;

  localparam int unsigned SampleW = 8;
  localparam int unsigned PixelW  = 32;
  localparam int unsigned ProdW   = 16;

  localparam int unsigned CoefR = 77;
  localparam int unsigned CoefG = 150;
  localparam int unsigned CoefB = 29;
  localparam int unsigned Round = 128;
  localparam int unsigned Shift = 8;

endpackage

// File: rtl/rgb_gray_pixel_mac.sv
// Two-stage weighted sum: stage 1 registers the three 16-bit products, stage 2 registers
// the rounded, shifted gray value.
module rgb_gray_pixel_mac
  import rgb_gray_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SampleW-1:0] red_i,
  input  logic [SampleW-1:0] green_i,
  input  logic [SampleW-1:0] blue_i,
  output logic [SampleW-1:0] gray_o
);

  logic [ProdW-1:0]   prod_r_d, prod_r_q;
  logic [ProdW-1:0]   prod_g_d, prod_g_q;
  logic [ProdW-1:0]   prod_b_d, prod_b_q;
  logic [ProdW-1:0]   sum_d;
  logic [SampleW-1:0] gray_d, gray_q;

  always_comb begin
    prod_r_d = ProdW'(red_i)   * ProdW'(CoefR);
    prod_g_d = ProdW'(green_i) * ProdW'(CoefG);
    prod_b_d = ProdW'(blue_i)  * ProdW'(CoefB);
  end

  // Worst case 255*256 + 128 = 65408, so the 16-bit sum cannot wrap.
  always_comb begin
    sum_d  = prod_r_q + prod_g_q + prod_b_q + ProdW'(Round);
    gray_d = SampleW'(sum_d >> Shift);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      gray_q   <= '0;
    end else begin
      prod_r_q <= prod_r_d;
      prod_g_q <= prod_g_d;
      prod_b_q <= prod_b_d;
      gray_q   <= gray_d;
    end
  end

  assign gray_o = gray_q;

endmodule

// File: rtl/rgb_gray_converter.sv
// RGB-to-grayscale converter: wraps the MAC pipeline, carries the pixel index alongside
// the data and raises a sticky done once the last (or any later) index has emerged.
module rgb_gray_converter
  import rgb_gray_pkg::*;
#(
  parameter int unsigned ROW = 1153,
  parameter int unsigned COL = 2048
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PixelW-1:0]  pixel,
  input  logic [SampleW-1:0] data_red,
  input  logic [SampleW-1:0] data_green,
  input  logic [SampleW-1:0] data_blue,
  output logic [SampleW-1:0] data_filtered,
  output logic               done
);

  localparam logic [PixelW-1:0] LastPixel = PixelW'(ROW * COL - 1);

  logic [PixelW-1:0] pixel_q;
  logic              done_d, done_q;

  rgb_gray_pixel_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .red_i   (data_red),
    .green_i (data_green),
    .blue_i  (data_blue),
    .gray_o  (data_filtered)
  );

  // Index sits in stage 1; done is registered on the edge that loads its gray result.
  always_comb begin
    done_d = done_q | (pixel_q >= LastPixel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_q <= '0;
      done_q  <= 1'b0;
    end else begin
      pixel_q <= pixel;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_rgb_gray_converter.sv
// Self-checking bench for rgb_gray_converter (ROW=2, COL=2): scoreboard of expected
// gray/index pairs, popped as each result leaves the two-stage pipeline.
module tb_rgb_gray_converter;

  localparam int unsigned Last = 3;

  typedef struct {
    logic [7:0]  gray;
    logic [31:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pixel = '0;
  logic [7:0]  data_red = '0;
  logic [7:0]  data_green = '0;
  logic [7:0]  data_blue = '0;
  logic [7:0]  data_filtered;
  logic        done;

  exp_t sb[$];
  logic mdl_done = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  rgb_gray_converter #(
    .ROW (2),
    .COL (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pixel         (pixel),
    .data_red      (data_red),
    .data_green    (data_green),
    .data_blue     (data_blue),
    .data_filtered (data_filtered),
    .done          (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_gray(input int r, input int g, input int b);
    int s;
    s = 77 * r + 150 * g + 29 * b + 128;
    return 8'(s >> 8);
  endfunction

  // Present one pixel, let the sampling edge pass, and record what it should become.
  task automatic tick(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [31:0] idx);
    exp_t e;
    data_red   = r;
    data_green = g;
    data_blue  = b;
    pixel      = idx;
    @(posedge clk);
    #1;
    e.gray = model_gray(int'(r), int'(g), int'(b));
    e.idx  = idx;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    data_red = 8'd255; data_green = 8'd255; data_blue = 8'd255; pixel = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (data_filtered !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %0d want 0", data_filtered);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_colours;
    logic [7:0] tr[7] = '{8'd255, 8'd0, 8'd255, 8'd0,   8'd0,  8'd128, 8'd0};
    logic [7:0] tg[7] = '{8'd255, 8'd0, 8'd0,   8'd255, 8'd0,  8'd128, 8'd0};
    logic [7:0] tb[7] = '{8'd255, 8'd0, 8'd0,   8'd0,   8'd255, 8'd128, 8'd0};
    logic [7:0] tw[7] = '{8'd255, 8'd0, 8'd77,  8'd149, 8'd29, 8'd128, 8'd0};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      tick(tr[i], tg[i], tb[i], 32'd0);
      if (i > 0) begin
        n_cmp++;
        if (data_filtered !== tw[i-1]) begin
          n_bad++;
          $display("FAIL colour_%0d: got %0d want %0d", i - 1, data_filtered, tw[i-1]);
        end
      end
      if (sb.size() > 1) begin
        e = sb.pop_front();
        if (e.idx >= Last) mdl_done = 1'b1;
        n_cmp++;
        if (data_filtered !== e.gray) begin
          n_bad++;
          $display("FAIL colour_sb_data: got %0d want %0d", data_filtered, e.gray);
        end
        n_cmp++;
        if (done !== mdl_done) begin
          n_bad++;
          $display("FAIL colour_sb_done: got %b want %b", done, mdl_done);
        end
      end
    end
  endtask

  task automatic test_streaming;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      tick(8'($urandom), 8'($urandom), 8'($urandom), 32'(i % 3));
      if (sb.size() > 1) begin
        e = sb.pop_front();
        if (e.idx >= Last) mdl_done = 1'b1;
        n_cmp++;
        if (data_filtered !== e.gray) begin
          n_bad++;
          $display("FAIL stream_data_%0d: got %0d want %0d", i, data_filtered, e.gray);
        end
        n_cmp++;
        if (done !== mdl_done) begin
          n_bad++;
          $display("FAIL stream_done_%0d: got %b want %b", i, done, mdl_done);
        end
      end
    end
  endtask

  task automatic test_done;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      tick(8'($urandom), 8'($urandom), 8'($urandom), 32'(i % 4));
      // The edge that samples index 3 must not yet raise done.
      if (i == 3) begin
        n_cmp++;
        if (done !== 1'b0) begin
          n_bad++;
          $display("FAIL done_early: got %b want 0", done);
        end
      end
      if (i >= 4) begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_bad++;
          $display("FAIL done_sticky_%0d: got %b want 1", i, done);
        end
      end
      if (sb.size() > 1) begin
        e = sb.pop_front();
        if (e.idx >= Last) mdl_done = 1'b1;
        n_cmp++;
        if (data_filtered !== e.gray) begin
          n_bad++;
          $display("FAIL done_sb_data_%0d: got %0d want %0d", i, data_filtered, e.gray);
        end
        n_cmp++;
        if (done !== mdl_done) begin
          n_bad++;
          $display("FAIL done_sb_done_%0d: got %b want %b", i, done, mdl_done);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stream;
    exp_t e;
    for (int i = 0; i < 3; i++) tick(8'd200, 8'd210, 8'd220, 32'(i));
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (data_filtered !== 8'd0) begin
      n_bad++;
      $display("FAIL midrst_data: got %0d want 0", data_filtered);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_done: got %b want 0", done);
    end
    sb.delete();
    mdl_done = 1'b0;
    data_red = 8'd255; data_green = 8'd255; data_blue = 8'd255; pixel = 32'd3;
    @(posedge clk);
    #1;
    n_cmp++;
    if (data_filtered !== 8'd0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_hold: got data %0d done %b want 0 0", data_filtered, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(8'($urandom), 8'($urandom), 8'($urandom), 32'(i % 3));
      if (i == 0) begin
        n_cmp++;
        if (data_filtered !== 8'd0 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL midrst_stale: got data %0d done %b want 0 0", data_filtered, done);
        end
      end
      if (sb.size() > 1) begin
        e = sb.pop_front();
        if (e.idx >= Last) mdl_done = 1'b1;
        n_cmp++;
        if (data_filtered !== e.gray) begin
          n_bad++;
          $display("FAIL midrst_sb_data_%0d: got %0d want %0d", i, data_filtered, e.gray);
        end
        n_cmp++;
        if (done !== mdl_done) begin
          n_bad++;
          $display("FAIL midrst_sb_done_%0d: got %b want %b", i, done, mdl_done);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_colours();
    test_streaming();
    test_done();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
